scroll_scan_ctrl: RTL and testbench
===================================

// Module: scroll_scan_ctrl
// PURPOSE
//  Controller for the 4-digit scrolling hex display. Sequences scrolling of a 4-bit base index.
//  Digit k (k=0 leftmost) shows (base+k) mod 16. Time-multiplexes the four 7-seg digits.
//  Sits between board buttons/switches and the 7-seg pins; supports run/stop, single-step,
//  direction select and direct load.
// PARAMETERS
//  SCROLL_DIV  50_000_000  clk cycles per scroll step in RUN (1 Hz @ 50 MHz); min 2
//  SCAN_DIV    50_000      clk cycles each digit is lit before advancing scan; min 2
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  rst       in   1  reset, asynchronous, active-low (rst==0 resets)
//  run       in   1  level: 1 = auto-scroll, 0 = stopped (synchronised externally)
//  step_req  in   1  single-cycle pulse: advance one position (honoured only in STOP)
//  dir       in   1  0 = base increments, 1 = base decrements
//  load      in   1  single-cycle pulse: base <= load_val
//  load_val  in   4  value for load
//  base      out  4  current leftmost digit value
//  step_done out  1  1-cycle pulse the cycle after base changes by a step (not by load)
//  an        out  4  digit enables, active-low, one-hot; an[3] = leftmost
//  seg       out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset: state=STOP, base=0, prescaler=0, scan count=0, sel=0, step_done=0,
//    an=4'b1111, seg=7'h7F (blank).
//  FSM (2 states, registered):
//    STOP: run==1 -> RUN (prescaler starts from 0); else stay.
//    RUN : run==0 -> STOP (prescaler cleared to 0 same edge); else stay.
//  Prescaler: counts 0..SCROLL_DIV-1 only while state==RUN && run==1; held at 0 otherwise.
//    tick = (state==RUN && run==1 && presc==SCROLL_DIV-1).
//    First step lands SCROLL_DIV cycles after the edge that enters RUN.
//  Step source: tick in RUN; step_req while state==STOP. step_req in RUN is ignored.
//    Not queued.
//  Step arithmetic: base <= dir ? base-1 : base+1, 4-bit natural wrap (F+1=0, 0-1=F).
//    dir sampled on the stepping edge.
//  Priority on the same edge: load > step. load wins; no step_done for that edge.
//    The tick is consumed (prescaler still wraps to 0).
//  step_done registered: high exactly one cycle after each stepping edge.
//  Scan: counter 0..SCAN_DIV-1 runs free in both states. On wrap, sel <= sel+1 (2-bit wrap).
//    On the same edge: an <= ~(4'b0001<<sel_next),
//    seg <= hex7(base + (3-sel_next)) computed from the base value after this edge.
//  an and seg change on the same edge: never a cycle with mismatched digit/segments.
//    Display stays blank until the first scan wrap after reset.
//  A base change between scan wraps shows on the next wrap (max SCAN_DIV-cycle lag).
//  Digit arithmetic is mod 16 (4-bit add, carry dropped); no subtract-15 correction.
//  Reset asserted mid-operation: all registers return to reset values immediately (async).
//    Deassertion resumes from STOP.
// STRUCTURE
//  Shared package (scroll_pkg): state encodings ST_STOP=1'b0, ST_RUN=1'b1; SEG_BLANK=7'h7F;
//    AN_OFF=4'hF.
//  One sub-module: hex7seg (combinational 4-bit -> 7-bit active-low decode, 0..F incl. A-F).
//    Instantiated once on the selected digit value.
//  Top holds FSM, prescaler, base register, scan counter/sel, output registers.
// TESTING (SCROLL_DIV=4, SCAN_DIV=2 unless noted)
//  1 Reset: rst=0 mid-run -> base=0, an=F, seg=7F, step_done=0 within same cycle; stays STOP.
//  2 run=1,dir=0 from base=E -> base E->F->0->1 at 4-cycle spacing, step_done each;
//    first step 4 cycles after RUN entry.
//  3 STOP, dir=1, base=0, step_req pulse -> base=F next edge, step_done one cycle later;
//    step_req during RUN -> no change.
//  4 load=1,load_val=9 coincident with tick -> base=9, no step_done; next tick -> A.
//  5 Scan: base=C, stopped -> an cycles E,D,B,7 (SCAN_DIV=2: 2 cycles each);
//    seg = hex7(F),hex7(E),hex7(D),hex7(C), i.e. 0E,06,21,46.
//  6 run dropped on the cycle presc==3 -> no step, state STOP; re-raise -> full 4 cycles to next step.

Source files
------------

// File: rtl/scroll_pkg.sv
// Shared encodings and widths for the scrolling hex display controller.
package scroll_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [AN_W-1:0]  AN_OFF    = 4'hF;

endpackage

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low 7-segment decode, bit order {g,f,e,d,c,b,a}.
module hex7seg
  import scroll_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [SEG_W-1:0]   seg_c_o
);

  always_comb begin
    seg_c_o = SEG_BLANK;
    unique case (digit_i)
      4'h0: seg_c_o = 7'h40;
      4'h1: seg_c_o = 7'h79;
      4'h2: seg_c_o = 7'h24;
      4'h3: seg_c_o = 7'h30;
      4'h4: seg_c_o = 7'h19;
      4'h5: seg_c_o = 7'h12;
      4'h6: seg_c_o = 7'h02;
      4'h7: seg_c_o = 7'h78;
      4'h8: seg_c_o = 7'h00;
      4'h9: seg_c_o = 7'h10;
      4'hA: seg_c_o = 7'h08;
      4'hB: seg_c_o = 7'h03;
      4'hC: seg_c_o = 7'h46;
      4'hD: seg_c_o = 7'h21;
      4'hE: seg_c_o = 7'h06;
      4'hF: seg_c_o = 7'h0E;
      default: seg_c_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/scroll_scan_ctrl.sv
// Scrolling 4-digit hex display controller: run/stop/step/load of a base index
// plus time-multiplexed digit scan with registered anode and segment outputs.
module scroll_scan_ctrl
  import scroll_pkg::*;
#(
  parameter int unsigned SCROLL_DIV = 50_000_000,
  parameter int unsigned SCAN_DIV   = 50_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               step_req,
  input  logic               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] base,
  output logic               step_done,
  output logic [AN_W-1:0]    an,
  output logic [SEG_W-1:0]   seg
);

  localparam int unsigned PRESC_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e               state_q, state_d;
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [DIGIT_W-1:0]   base_q, base_d;
  logic                 step_done_q, step_done_d;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [AN_W-1:0]      an_q, an_d;
  logic [SEG_W-1:0]     seg_q, seg_d;

  logic                 run_active;
  logic                 tick;
  logic                 step;
  logic                 scan_wrap;
  logic [SEL_W-1:0]     digit_ofs;
  logic [DIGIT_W-1:0]   digit_val;
  logic [SEG_W-1:0]     digit_seg;

  // Next-state logic for the run/stop FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  // Prescaler, base stepping and scan sequencing
  always_comb begin
    run_active  = (state_q == ST_RUN) && run;
    tick        = run_active && (presc_q == PRESC_W'(SCROLL_DIV - 1));
    presc_d     = '0;
    if (run_active && !tick) presc_d = presc_q + PRESC_W'(1);

    // step_req is only honoured while stopped; load overrides any step on the same edge
    step        = tick || ((state_q == ST_STOP) && step_req);
    base_d      = base_q;
    step_done_d = 1'b0;
    if (load) begin
      base_d = load_val;
    end else if (step) begin
      base_d      = dir ? (base_q - DIGIT_W'(1)) : (base_q + DIGIT_W'(1));
      step_done_d = 1'b1;
    end

    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : (scan_q + SCAN_W'(1));
    sel_d     = scan_wrap ? (sel_q + SEL_W'(1)) : sel_q;

    // sel 0 drives the rightmost digit, which shows base+3
    digit_ofs = SEL_W'(3) - sel_d;
    digit_val = base_d + {{(DIGIT_W-SEL_W){1'b0}}, digit_ofs};

    an_d  = an_q;
    seg_d = seg_q;
    if (scan_wrap) begin
      an_d  = ~(AN_W'(1) << sel_d);
      seg_d = digit_seg;
    end
  end

  hex7seg u_hex7seg (
    .digit_i (digit_val),
    .seg_c_o (digit_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_STOP;
      presc_q     <= '0;
      base_q      <= '0;
      step_done_q <= 1'b0;
      scan_q      <= '0;
      sel_q       <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      base_q      <= base_d;
      step_done_q <= step_done_d;
      scan_q      <= scan_d;
      sel_q       <= sel_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign base      = base_q;
  assign step_done = step_done_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_scroll_scan_ctrl.sv
// Self-checking bench for scroll_scan_ctrl with SCROLL_DIV=4, SCAN_DIV=2.
module tb_scroll_scan_ctrl;

  localparam int unsigned SCROLL_DIV = 4;
  localparam int unsigned SCAN_DIV   = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       run = 1'b0;
  logic       step_req = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] base;
  logic       step_done;
  logic [3:0] an;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       run;
    logic       step_req;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] exp_base;
    logic       exp_sd;
  } vec_t;

  typedef struct {
    logic [3:0] base;
    logic       sd;
    int         idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  scroll_scan_ctrl #(
    .SCROLL_DIV (SCROLL_DIV),
    .SCAN_DIV   (SCAN_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_req  (step_req),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .base      (base),
    .step_done (step_done),
    .an        (an),
    .seg       (seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7_ref(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic l,
                              input logic [3:0] lv, input logic [3:0] eb, input logic esd);
    vec_t v;
    v.run = r; v.step_req = s; v.dir = d; v.load = l;
    v.load_val = lv; v.exp_base = eb; v.exp_sd = esd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Drive one cycle of inputs at a negedge; compare after the following posedge
  task automatic apply_vec(input vec_t v, input int idx);
    exp_t e;
    run = v.run; step_req = v.step_req; dir = v.dir; load = v.load; load_val = v.load_val;
    e.base = v.exp_base; e.sd = v.exp_sd; e.idx = idx;
    sb_q.push_back(e);
    @(negedge clk);
    step_req = 1'b0;
    load     = 1'b0;
    e = sb_q.pop_front();
    chk($sformatf("vec%0d base", e.idx), 7'(base), 7'(e.base));
    chk($sformatf("vec%0d step_done", e.idx), 7'(step_done), 7'(e.sd));
  endtask

  // Load a base while stopped, then verify a full scan rotation starting at sel=0
  task automatic scan_check(input logic [3:0] b, input int idx);
    logic [3:0] prev;
    logic [3:0] an_exp;
    logic [3:0] dig;
    bit found;
    apply_vec(mk(1'b0, 1'b0, 1'b0, 1'b1, b, b, 1'b0), idx);
    prev  = an;
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      @(negedge clk);
      if (an == 4'hE && prev == 4'h7) found = 1'b1;
      else prev = an;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL scan%0d start: an=%h never moved from 7 to E", idx, an);
    end else begin
      for (int j = 0; j < 8; j++) begin
        if (j != 0) @(negedge clk);
        an_exp = ~(4'b0001 << (j / 2));
        dig    = b + 4'(3 - (j / 2));
        chk($sformatf("scan%0d an[%0d]", idx, j), 7'(an), 7'(an_exp));
        chk($sformatf("scan%0d seg[%0d]", idx, j), seg, hex7_ref(dig));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Stopped: decrement wrap, increment wrap, load, load-over-step
    vecs.push_back(mk(0, 1, 1, 0, 4'h0, 4'hF, 1));
    vecs.push_back(mk(0, 0, 1, 0, 4'h0, 4'hF, 0));
    vecs.push_back(mk(0, 1, 0, 0, 4'h0, 4'h0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 4'hE, 4'hE, 0));
    vecs.push_back(mk(0, 1, 0, 1, 4'h5, 4'h5, 0));
    vecs.push_back(mk(0, 0, 0, 1, 4'hE, 4'hE, 0));
    // Run from E: steps every 4 cycles, step_req ignored while running
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hE, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hF, 1));
    vecs.push_back(mk(1, 1, 0, 0, 4'h0, 4'hF, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hF, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 1));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h1, 1));
    // dir sampled on the stepping edge: decrement 1 -> 0
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 1, 0, 4'h0, 4'h1, 0));
    vecs.push_back(mk(1, 0, 1, 0, 4'h0, 4'h0, 1));
    // Load coincident with tick: load wins, no step_done, next tick from 9
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 4'h9, 4'h9, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'h9, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hA, 1));
    // run dropped when presc==3: no step; re-raise needs a full 4 cycles
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hA, 0));
    vecs.push_back(mk(0, 0, 0, 0, 4'h0, 4'hA, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hA, 0));
    vecs.push_back(mk(1, 0, 0, 0, 4'h0, 4'hB, 1));

    // Asynchronous reset at startup, checked before any clock edge
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("por base", 7'(base), 7'h0);
    chk("por an", 7'(an), 7'hF);
    chk("por seg", seg, 7'h7F);
    chk("por step_done", 7'(step_done), 7'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("blank before first wrap an", 7'(an), 7'hF);
    chk("blank before first wrap seg", seg, 7'h7F);

    foreach (vecs[i]) apply_vec(vecs[i], i);

    // Mid-run reset while step_done is high: takes effect without a clock edge
    #2 rst = 1'b0;
    #1;
    chk("midrun rst base", 7'(base), 7'h0);
    chk("midrun rst an", 7'(an), 7'hF);
    chk("midrun rst seg", seg, 7'h7F);
    chk("midrun rst step_done", 7'(step_done), 7'h0);
    run = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    apply_vec(mk(0, 0, 0, 0, 4'h0, 4'h0, 0), 100);
    chk("post rst blank an", 7'(an), 7'hF);
    // Resumed in STOP: step_req is honoured
    apply_vec(mk(0, 1, 0, 0, 4'h0, 4'h1, 1), 101);
    apply_vec(mk(0, 0, 0, 0, 4'h0, 4'h1, 0), 102);

    scan_check(4'hC, 200);
    scan_check(4'h0, 201);
    scan_check(4'h4, 202);
    scan_check(4'h8, 203);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
